// File: rtl/interrupt_priority_arbiter_pkg.sv
// Shared types and helpers for the interrupt priority arbiter.
// Holds the arbiter FSM states, the "no interrupt" ID and the index-to-ID mapping.
package interrupt_priority_arbiter_pkg;

  typedef enum logic [1:0] {IDLE, SCAN, PRESENT, SERVICE} arb_state_e;

  localparam logic [31:0] ID_NONE = 32'd0;

  // Source index i is reported to software as ID i+1, leaving 0 free for "none".
  function automatic logic [31:0] id_from_idx(input logic [31:0] idx);
    return idx + 32'd1;
  endfunction

endpackage

// File: rtl/interrupt_priority_arbiter_gateway.sv
// Per-source gateway: latches a level request into a pending bit and blocks
// re-arming while the source is in service (claimed but not yet completed).
module interrupt_gateway (
  input  logic clk,
  input  logic rst,
  input  logic req,
  input  logic claim,
  input  logic complete,
  output logic pending
);

  logic pending_q, pending_d;
  logic in_service_q, in_service_d;

  always_comb begin
    pending_d    = pending_q;
    in_service_d = in_service_q;
    if (req && !pending_q && !in_service_q) pending_d = 1'b1;
    // Claim overrides a simultaneous set.
    if (claim) begin
      pending_d    = 1'b0;
      in_service_d = 1'b1;
    end else if (complete) begin
      in_service_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pending_q    <= 1'b0;
      in_service_q <= 1'b0;
    end else begin
      pending_q    <= pending_d;
      in_service_q <= in_service_d;
    end
  end

  assign pending = pending_q;

endmodule

// File: rtl/interrupt_priority_arbiter.sv
// Serial priority arbiter for one interrupt context: scans one source per cycle,
// presents the winner and sequences the claim/complete handshake.
module interrupt_priority_arbiter
  import interrupt_priority_arbiter_pkg::*;
#(
  parameter int N_interrupts = 32,
  parameter int PRIO_W       = 3
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [N_interrupts-1:0]         interrupt_requests,
  input  logic                            prio_wen,
  input  logic [$clog2(N_interrupts)-1:0] prio_idx,
  input  logic [PRIO_W-1:0]               prio_wdata,
  input  logic [PRIO_W-1:0]               threshold,
  input  logic                            claim,
  input  logic                            complete,
  input  logic [31:0]                     complete_id,
  output logic [31:0]                     active_interrupt_ID,
  output logic [N_interrupts-1:0]         active_interrupt,
  output logic                            interrupt_processing,
  output logic                            irq_out,
  output logic [N_interrupts-1:0]         pending
);

  localparam int IW = $clog2(N_interrupts);
  localparam logic [IW-1:0] LAST_IDX = IW'(N_interrupts - 1);

  logic [N_interrupts-1:0][PRIO_W-1:0] prio_q, prio_d;
  arb_state_e                          state_q, state_d;
  logic [IW-1:0]                       scan_q, scan_d;
  logic [31:0]                         best_id_q, best_id_d, act_id_q, act_id_d, nb_id;
  logic [PRIO_W-1:0]                   best_prio_q, best_prio_d, thr_q, thr_d, nb_prio;
  logic [N_interrupts-1:0]             act_vec_q, act_vec_d, nb_vec, claim_vec, done_vec;
  logic                                proc_q, proc_d, irq_q, irq_d, hit;

  for (genvar i = 0; i < N_interrupts; i++) begin : g_gw
    interrupt_gateway u_gw (
      .clk      (clk),
      .rst      (rst),
      .req      (interrupt_requests[i]),
      .claim    (claim_vec[i]),
      .complete (done_vec[i]),
      .pending  (pending[i])
    );
  end

  always_comb begin
    prio_d = prio_q;
    if (prio_wen && (32'(prio_idx) < 32'(N_interrupts))) prio_d[prio_idx] = prio_wdata;
  end

  // Strict greater-than keeps the earlier index on ties.
  always_comb begin
    hit     = pending[scan_q] && (prio_q[scan_q] > best_prio_q);
    nb_id   = hit ? id_from_idx(32'(scan_q)) : best_id_q;
    nb_prio = hit ? prio_q[scan_q] : best_prio_q;
    for (int i = 0; i < N_interrupts; i++) nb_vec[i] = (nb_id == id_from_idx(32'(i)));
  end

  always_comb begin
    state_d     = state_q;
    scan_d      = scan_q;
    best_id_d   = best_id_q;
    best_prio_d = best_prio_q;
    act_id_d    = act_id_q;
    act_vec_d   = act_vec_q;
    proc_d      = 1'b0;
    irq_d       = irq_q;
    thr_d       = threshold;
    claim_vec   = '0;
    done_vec    = '0;
    unique case (state_q)
      IDLE: if (|pending) begin
        state_d     = SCAN;
        scan_d      = '0;
        best_id_d   = ID_NONE;
        best_prio_d = threshold;
      end
      SCAN: begin
        best_id_d   = nb_id;
        best_prio_d = nb_prio;
        if (scan_q == LAST_IDX) begin
          if (nb_id != ID_NONE) begin
            act_id_d  = nb_id;
            act_vec_d = nb_vec;
            proc_d    = 1'b1;
            irq_d     = 1'b1;
            state_d   = PRESENT;
          end else begin
            state_d = IDLE;
          end
        end else begin
          scan_d = scan_q + 1'b1;
        end
      end
      PRESENT: if (claim) begin
        claim_vec = act_vec_q;
        irq_d     = 1'b0;
        state_d   = SERVICE;
      end else if (prio_wen || (threshold != thr_q)) begin
        // Priorities or threshold moved under us: the winner may be stale.
        act_id_d    = ID_NONE;
        act_vec_d   = '0;
        irq_d       = 1'b0;
        state_d     = SCAN;
        scan_d      = '0;
        best_id_d   = ID_NONE;
        best_prio_d = threshold;
      end
      SERVICE: if (complete && (complete_id == act_id_q)) begin
        done_vec  = act_vec_q;
        act_id_d  = ID_NONE;
        act_vec_d = '0;
        state_d   = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prio_q      <= '0;
      state_q     <= IDLE;
      scan_q      <= '0;
      best_id_q   <= ID_NONE;
      best_prio_q <= '0;
      act_id_q    <= ID_NONE;
      act_vec_q   <= '0;
      proc_q      <= 1'b0;
      irq_q       <= 1'b0;
      thr_q       <= '0;
    end else begin
      prio_q      <= prio_d;
      state_q     <= state_d;
      scan_q      <= scan_d;
      best_id_q   <= best_id_d;
      best_prio_q <= best_prio_d;
      act_id_q    <= act_id_d;
      act_vec_q   <= act_vec_d;
      proc_q      <= proc_d;
      irq_q       <= irq_d;
      thr_q       <= thr_d;
    end
  end

  assign active_interrupt_ID  = act_id_q;
  assign active_interrupt     = act_vec_q;
  assign interrupt_processing = proc_q;
  assign irq_out              = irq_q;

endmodule

// File: tb/tb_interrupt_priority_arbiter.sv
// Self-checking bench for interrupt_priority_arbiter with N=8: directed scenarios
// plus randomized priority/request sets checked against a winner-selection model.
module tb_interrupt_priority_arbiter;

  localparam int N = 8;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [N-1:0] req = '0;
  logic         prio_wen = 1'b0;
  logic [2:0]   prio_idx = '0;
  logic [2:0]   prio_wdata = '0;
  logic [2:0]   threshold = '0;
  logic         claim = 1'b0;
  logic         complete = 1'b0;
  logic [31:0]  complete_id = '0;
  logic [31:0]  act_id;
  logic [N-1:0] act_vec;
  logic         proc, irq;
  logic [N-1:0] pend;

  int checks = 0;
  int errors = 0;
  int mprio[N];

  interrupt_priority_arbiter #(.N_interrupts(N), .PRIO_W(3)) dut (
    .clk(clk), .rst(rst), .interrupt_requests(req), .prio_wen(prio_wen),
    .prio_idx(prio_idx), .prio_wdata(prio_wdata), .threshold(threshold),
    .claim(claim), .complete(complete), .complete_id(complete_id),
    .active_interrupt_ID(act_id), .active_interrupt(act_vec),
    .interrupt_processing(proc), .irq_out(irq), .pending(pend)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; req = '0; threshold = '0; claim = 1'b0; complete = 1'b0; prio_wen = 1'b0;
    for (int i = 0; i < N; i++) mprio[i] = 0;
    tick(); rst = 1'b0;
  endtask

  task automatic write_prio(input int idx, input int val);
    prio_wen = 1'b1; prio_idx = 3'(idx); prio_wdata = 3'(val); mprio[idx] = val;
    tick(); prio_wen = 1'b0;
  endtask

  task automatic pulse_req(input logic [N-1:0] v);
    req = v; tick(); req = '0;
  endtask

  task automatic do_claim();
    claim = 1'b1; tick(); claim = 1'b0;
  endtask

  task automatic do_complete(input int id);
    complete = 1'b1; complete_id = 32'(id); tick(); complete = 1'b0;
  endtask

  task automatic wait_irq(input string name);
    int n = 0;
    while (!irq && n < 4 * N) begin tick(); n++; end
    checks++;
    if (irq !== 1'b1) begin errors++; $display("FAIL %s irq timeout got %b exp 1", name, irq); end
  endtask

  // Lowest index among the highest priorities strictly above the threshold; -1 if none.
  function automatic int winner(input logic [N-1:0] p, input int thr);
    int w = -1;
    int bp = thr;
    for (int i = 0; i < N; i++) if (p[i] && mprio[i] > bp) begin bp = mprio[i]; w = i; end
    return w;
  endfunction

  task automatic test_reset();
    rst = 1'b1; tick();
    checks++;
    if ({act_id, act_vec, proc, irq, pend} !== '0) begin
      errors++; $display("FAIL reset outputs got id=%0h vec=%0h proc=%b irq=%b pend=%0h exp 0", act_id, act_vec, proc, irq, pend);
    end
    rst = 1'b0;
  endtask

  task automatic test_latency();
    int procs = 0;
    do_reset();
    write_prio(3, 2);
    req[3] = 1'b1; tick(); req = '0;
    checks++;
    if (pend !== 8'h08) begin errors++; $display("FAIL lat_pending got %0h exp 08", pend); end
    for (int k = 2; k <= 9; k++) begin
      tick(); if (proc) procs++;
      checks++;
      if (irq !== 1'b0) begin errors++; $display("FAIL lat_early k=%0d irq got %b exp 0", k, irq); end
    end
    tick(); if (proc) procs++;
    checks++;
    if ({irq, act_id, act_vec} !== {1'b1, 32'd4, 8'h08}) begin
      errors++; $display("FAIL lat_present irq=%b id=%0d vec=%0h exp 1/4/08", irq, act_id, act_vec);
    end
    for (int k = 0; k < 3; k++) begin tick(); if (proc) procs++; end
    checks++;
    if (procs !== 1) begin errors++; $display("FAIL lat_proc_pulses got %0d exp 1", procs); end
  endtask

  task automatic test_tie();
    do_reset();
    write_prio(2, 5); write_prio(6, 5);
    pulse_req(8'h44);
    wait_irq("tie");
    checks++;
    if ({act_id, act_vec} !== {32'd3, 8'h04}) begin errors++; $display("FAIL tie_id got %0d/%0h exp 3/04", act_id, act_vec); end
    do_claim();
    checks++;
    if ({irq, act_id, pend} !== {1'b0, 32'd3, 8'h40}) begin
      errors++; $display("FAIL tie_claim irq=%b id=%0d pend=%0h exp 0/3/40", irq, act_id, pend);
    end
    do_complete(3);
    checks++;
    if ({act_id, act_vec} !== '0) begin errors++; $display("FAIL tie_complete id=%0d exp 0", act_id); end
    wait_irq("tie2");
    checks++;
    if (act_id !== 32'd7) begin errors++; $display("FAIL tie_second id got %0d exp 7", act_id); end
  endtask

  task automatic test_threshold();
    int seen = 0;
    do_reset();
    write_prio(1, 2); threshold = 3'd2;
    pulse_req(8'h02);
    for (int k = 0; k < 3 * N; k++) begin tick(); if (irq || proc) seen++; end
    checks++;
    if (seen !== 0) begin errors++; $display("FAIL thr_block presented %0d cycles exp 0", seen); end
    threshold = 3'd1;
    wait_irq("thr");
    checks++;
    if (act_id !== 32'd2) begin errors++; $display("FAIL thr_lower id got %0d exp 2", act_id); end
  endtask

  task automatic test_rescan();
    do_reset();
    write_prio(3, 2);
    pulse_req(8'h08);
    wait_irq("rescan");
    req[5] = 1'b1; tick(); req = '0;
    write_prio(5, 7);
    checks++;
    if ({irq, act_id, act_vec} !== '0) begin errors++; $display("FAIL rescan_drop irq=%b id=%0d exp 0/0", irq, act_id); end
    wait_irq("rescan2");
    checks++;
    if ({act_id, act_vec} !== {32'd6, 8'h20}) begin errors++; $display("FAIL rescan_id got %0d/%0h exp 6/20", act_id, act_vec); end
  endtask

  task automatic test_service();
    do_reset();
    write_prio(3, 2);
    pulse_req(8'h08);
    wait_irq("svc");
    do_claim();
    do_complete(5);
    checks++;
    if (act_id !== 32'd4) begin errors++; $display("FAIL svc_badid id got %0d exp 4", act_id); end
    req[3] = 1'b1; tick(); tick();
    checks++;
    if (pend[3] !== 1'b0) begin errors++; $display("FAIL svc_block pend3 got %b exp 0", pend[3]); end
    do_complete(4);
    checks++;
    if (act_id !== 32'd0) begin errors++; $display("FAIL svc_done id got %0d exp 0", act_id); end
    tick();
    checks++;
    if (pend[3] !== 1'b1) begin errors++; $display("FAIL svc_repend pend3 got %b exp 1", pend[3]); end
    req = '0;
  endtask

  task automatic test_reset_midscan();
    int seen = 0;
    do_reset();
    write_prio(3, 2);
    pulse_req(8'h08);
    for (int k = 0; k < 5; k++) tick();
    #2 rst = 1'b1; #1;
    checks++;
    if ({act_id, act_vec, proc, irq, pend} !== '0) begin errors++; $display("FAIL midscan_reset pend=%0h irq=%b exp 0", pend, irq); end
    tick(); rst = 1'b0; mprio[3] = 0;
    for (int k = 0; k < 3 * N; k++) begin tick(); if (proc || irq) seen++; end
    checks++;
    if (seen !== 0) begin errors++; $display("FAIL midscan_quiet active %0d cycles exp 0", seen); end
    pulse_req(8'h08);
    for (int k = 0; k < 3 * N; k++) begin tick(); if (proc || irq) seen++; end
    checks++;
    if (seen !== 0) begin errors++; $display("FAIL midscan_prio_cleared active %0d cycles exp 0", seen); end
  endtask

  task automatic test_random();
    for (int it = 0; it < 12; it++) begin
      logic [N-1:0] mpend;
      int thr, w;
      do_reset();
      for (int i = 0; i < N; i++) write_prio(i, int'($urandom_range(0, 7)));
      thr = int'($urandom_range(0, 3));
      threshold = 3'(thr);
      mpend = N'($urandom);
      pulse_req(mpend);
      for (int r = 0; r <= N; r++) begin
        w = winner(mpend, thr);
        if (w < 0) begin
          int seen = 0;
          for (int k = 0; k < 3 * N; k++) begin tick(); if (irq) seen++; end
          checks++;
          if (seen !== 0 || pend !== mpend) begin
            errors++; $display("FAIL rnd_none it=%0d irq_cycles=%0d pend=%0h exp 0/%0h", it, seen, pend, mpend);
          end
          break;
        end
        wait_irq("rnd");
        checks++;
        if ({act_id, act_vec} !== {32'(w + 1), N'(1 << w)}) begin
          errors++; $display("FAIL rnd_id it=%0d got %0d/%0h exp %0d/%0h", it, act_id, act_vec, w + 1, N'(1 << w));
        end
        do_claim();
        mpend[w] = 1'b0;
        checks++;
        if (pend !== mpend) begin errors++; $display("FAIL rnd_pend it=%0d got %0h exp %0h", it, pend, mpend); end
        do_complete(w + 1);
      end
    end
  endtask

  initial begin
    test_reset();
    test_latency();
    test_tie();
    test_threshold();
    test_rescan();
    test_service();
    test_reset_midscan();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
